// File: rtl/ife_pkg.sv
// Shared encodings for the image filter engine: filter modes,
// FSM states and the 3x3 window tap geometry helpers.
package ife_pkg;

    localparam logic [1:0] MODE_MEAN   = 2'b00;
    localparam logic [1:0] MODE_PASS   = 2'b01;
    localparam logic [1:0] MODE_MEDIAN = 2'b10;
    localparam logic [1:0] MODE_THRS   = 2'b11;

    localparam int NTAP    = 9;
    localparam int MED_IDX = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CALC  = 2'd2,
        S_WRITE = 2'd3
    } ife_state_e;

    // Window row of tap k (0 = row above, 2 = row below).
    function automatic logic [1:0] tap_row(input logic [3:0] k);
        logic [1:0] r;
        unique case (1'b1)
            (k < 4'd3):              r = 2'd0;
            (k >= 4'd3 && k < 4'd6): r = 2'd1;
            default:                 r = 2'd2;
        endcase
        return r;
    endfunction

    // Window column of tap k (0 = left, 2 = right).
    function automatic logic [1:0] tap_col(input logic [3:0] k);
        logic [1:0] c;
        case (k)
            4'd0, 4'd3, 4'd6: c = 2'd0;
            4'd1, 4'd4, 4'd7: c = 2'd1;
            default:          c = 2'd2;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ife_window_sorter.sv
// 3x3 window register array with a 9-pass odd-even transposition sort.
// Ports: clk/reset; load_i/load_idx_i/load_data_i write one tap;
// start_i begins sorting, done_o flags the last pass, med_o = element 4.
module ife_window_sorter
    import ife_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [3:0]    load_idx_i,
    input  logic [DW-1:0] load_data_i,
    input  logic          start_i,
    output logic          done_o,
    output logic [DW-1:0] med_o
);

    logic [DW-1:0] win_q [NTAP];
    logic [DW-1:0] win_d [NTAP];
    logic          run_q, run_d;
    logic [3:0]    pass_q, pass_d;

    always_comb begin
        for (int i = 0; i < NTAP; i++) begin
            win_d[i] = win_q[i];
        end
        run_d  = run_q;
        pass_d = pass_q;
        if (load_i) begin
            win_d[load_idx_i] = load_data_i;
        end
        if (start_i) begin
            run_d  = 1'b1;
            pass_d = '0;
        end else if (run_q) begin
            // Even passes compare (0,1),(2,3)..; odd passes (1,2),(3,4)..
            for (int i = 0; i < NTAP - 1; i++) begin
                if ((i[0] == pass_q[0]) && (win_q[i] > win_q[i+1])) begin
                    win_d[i]   = win_q[i+1];
                    win_d[i+1] = win_q[i];
                end
            end
            pass_d = pass_q + 4'd1;
            if (pass_q == 4'(NTAP - 1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAP; i++) begin
                win_q[i] <= '0;
            end
            run_q  <= 1'b0;
            pass_q <= '0;
        end else begin
            for (int i = 0; i < NTAP; i++) begin
                win_q[i] <= win_d[i];
            end
            run_q  <= run_d;
            pass_q <= pass_d;
        end
    end

    assign done_o = run_q && (pass_q == 4'(NTAP - 1));
    assign med_o  = win_q[MED_IDX];

endmodule

// File: rtl/ife_param.sv
// Image filter engine: reads an IMG_W x IMG_H image, applies mean,
// pass-through, median or threshold, writes one pixel per wen pulse.
// Ports: clk, reset (async, high); ready/sel/thresh start a frame;
// idata/iaddr read the input memory; busy, addr/data_wr/wen write out.
module ife_param
    import ife_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    input  logic [1:0]    sel,
    input  logic [DW-1:0] thresh,
    input  logic [DW-1:0] idata,
    output logic [AW-1:0] iaddr,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_wr,
    output logic          wen
);

    localparam int SW = DW + 4;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [AW-1:0] PIX_LAST = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [SW-1:0] DIV      = SW'(NTAP);
    localparam logic [7:0]    DIV_LAST = 8'(SW - 1);

    ife_state_e    st_q, st_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] thr_q, thr_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [3:0]    k_q, k_d;
    logic [7:0]    calc_q, calc_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] iaddr_q, iaddr_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [SW-2:0] rem_q, rem_d;
    logic [SW-1:0] quo_q, quo_d;
    logic [DW-1:0] res_q, res_d;

    logic          one_tap;
    logic          issue;
    logic [3:0]    tk;
    logic [1:0]    tr, tc;
    logic          tap_ok;
    logic [AW-1:0] tap_addr;
    logic [DW-1:0] tap;
    logic [SW-1:0] sum_nx;
    logic [SW-1:0] trial, diff;
    logic [DW-1:0] result;
    logic          srt_load, srt_start, srt_done;
    logic [DW-1:0] srt_med;

    assign one_tap = (mode_q == MODE_PASS) || (mode_q == MODE_THRS);
    assign issue   = (st_q == S_FETCH) &&
                     (one_tap ? (k_q == 4'd0) : (k_q < 4'd9));
    assign tk      = one_tap ? 4'd4 : k_q;
    assign tr      = tap_row(tk);
    assign tc      = tap_col(tk);

    // Taps hanging over an image edge are not read; they enter as 0.
    assign tap_ok = !((tr == 2'd0) && (row_q == '0))
                 && !((tr == 2'd2) && (row_q == ROW_LAST))
                 && !((tc == 2'd0) && (col_q == '0))
                 && !((tc == 2'd2) && (col_q == COL_LAST));

    always_comb begin
        tap_addr = pix_q;
        if (tr == 2'd0) begin
            tap_addr = tap_addr - ROW_STEP;
        end else if (tr == 2'd2) begin
            tap_addr = tap_addr + ROW_STEP;
        end
        if (tc == 2'd0) begin
            tap_addr = tap_addr - ONE;
        end else if (tc == 2'd2) begin
            tap_addr = tap_addr + ONE;
        end
    end

    assign iaddr  = (issue && tap_ok) ? tap_addr : iaddr_q;
    assign tap    = valid_q ? idata : '0;
    assign sum_nx = ((k_q == 4'd1) ? '0 : sum_q) + SW'(tap);
    assign trial  = {rem_q, quo_q[SW-1]};
    assign diff   = trial - DIV;

    assign srt_load  = (st_q == S_FETCH) && !one_tap && (k_q != 4'd0);
    assign srt_start = (st_q == S_FETCH) && (k_q == 4'd9) &&
                       (mode_q == MODE_MEDIAN);

    ife_window_sorter #(
        .DW (DW)
    ) u_sorter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (srt_load),
        .load_idx_i  (k_q - 4'd1),
        .load_data_i (tap),
        .start_i     (srt_start),
        .done_o      (srt_done),
        .med_o       (srt_med)
    );

    always_comb begin
        case (mode_q)
            MODE_MEDIAN: result = srt_med;
            MODE_MEAN:   result = quo_q[DW-1:0];
            default:     result = res_q;
        endcase
    end

    always_comb begin
        st_d    = st_q;
        mode_d  = mode_q;
        thr_d   = thr_q;
        pix_d   = pix_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        calc_d  = calc_q;
        sum_d   = sum_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        valid_d = issue && tap_ok;
        iaddr_d = iaddr;
        busy    = (st_q != S_IDLE);
        wen     = (st_q == S_WRITE);
        addr    = pix_q;
        data_wr = (st_q == S_WRITE) ? result : res_q;

        unique case (st_q)
            S_IDLE: begin
                if (ready) begin
                    st_d   = S_FETCH;
                    mode_d = sel;
                    thr_d  = thresh;
                    pix_d  = '0;
                    row_d  = '0;
                    col_d  = '0;
                    k_d    = '0;
                end
            end
            S_FETCH: begin
                k_d = k_q + 4'd1;
                if (!one_tap && (k_q != 4'd0)) begin
                    sum_d = sum_nx;
                end
                if (one_tap && (k_q == 4'd1)) begin
                    k_d  = '0;
                    st_d = S_WRITE;
                    if ((mode_q == MODE_THRS) && (tap < thr_q)) begin
                        res_d = '0;
                    end else begin
                        res_d = tap;
                    end
                end else if (!one_tap && (k_q == 4'd9)) begin
                    k_d    = '0;
                    st_d   = S_CALC;
                    calc_d = '0;
                    quo_d  = sum_nx;
                    rem_d  = '0;
                end
            end
            S_CALC: begin
                calc_d = calc_q + 8'd1;
                if (mode_q == MODE_MEAN) begin
                    // Restoring divide by 9, one quotient bit per cycle.
                    if (trial >= DIV) begin
                        rem_d = diff[SW-2:0];
                        quo_d = {quo_q[SW-2:0], 1'b1};
                    end else begin
                        rem_d = trial[SW-2:0];
                        quo_d = {quo_q[SW-2:0], 1'b0};
                    end
                    if (calc_q == DIV_LAST) begin
                        st_d = S_WRITE;
                    end
                end else if (srt_done) begin
                    st_d = S_WRITE;
                end
            end
            S_WRITE: begin
                res_d = result;
                if (pix_q == PIX_LAST) begin
                    st_d  = S_IDLE;
                    pix_d = '0;
                    row_d = '0;
                    col_d = '0;
                end else begin
                    st_d  = S_FETCH;
                    pix_d = pix_q + ONE;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= S_IDLE;
            mode_q  <= MODE_MEAN;
            thr_q   <= '0;
            pix_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            calc_q  <= '0;
            valid_q <= 1'b0;
            iaddr_q <= '0;
            sum_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
        end else begin
            st_q    <= st_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
            pix_q   <= pix_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            calc_q  <= calc_d;
            valid_q <= valid_d;
            iaddr_q <= iaddr_d;
            sum_q   <= sum_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: doc/ife_param.md
# ife_param

- Parametrised image filter engine for IMG_W×IMG_H images of DW-bit pixels.
- Reads one image from the input pixel memory, applies the mode chosen by `sel`, and writes the filtered image to the output memory, one pixel per write.
- Modes: 3×3 mean, pass-through, 3×3 median, programmable threshold.
- Sits between the host handshake (`ready`/`busy`) and the two image memories. 3×3 windows are zero-padded at the image borders.

## Interface
Parameters:
- DW, 8, pixel width in bits
- IMG_W, 128, image width in pixels (≥3)
- IMG_H, 128, image height in pixels (≥3)
- AW, $clog2(IMG_W*IMG_H), pixel address width (derived; not overridden)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- ready  in  1  start request, sampled only in IDLE
- sel  in  2  mode: 00 mean, 01 pass-through, 10 median, 11 threshold; latched at start
- thresh  in  DW  threshold value; latched at start
- idata  in  DW  input memory read data, valid one cycle after `iaddr`
- iaddr  out  AW  input memory read address
- busy  out  1  high from the cycle after accepted start until the cycle after the last write
- addr  out  AW  output memory write address
- data_wr  out  DW  output memory write data
- wen  out  1  output memory write enable, one-cycle pulse per pixel

## Operation
- Pixel (r,c) has address r·IMG_W+c. Pixels are processed in raster order.
- States and transitions:
  - IDLE → FETCH when `ready` is high; `sel` and `thresh` are latched in the same cycle.
  - FETCH: issues the window reads.
  - CALC: median/mean only.
  - WRITE: one cycle.
  - WRITE → FETCH for the next pixel, or → IDLE after pixel IMG_W·IMG_H−1.
- FETCH, median/mean: 9 taps in row-major window order k=0..8, (r−1,c−1) … (r+1,c+1).
  - One address per cycle; captured one cycle later, so FETCH lasts 10 cycles.
  - A tap outside the image forces a 0 into the window; `iaddr` holds its previous value.
- FETCH, threshold/pass: single centre tap, 2 cycles (issue, capture).
- Median CALC: 9 cycles of odd-even transposition passes over the 9 taps; result is sorted element 4.
- Mean CALC:
  - Sum width SW = DW+4; the 9-tap sum is formed during capture.
  - Result = floor(sum/9), via a restoring divider with a fixed SW cycles.
- Threshold: data_wr = (pixel < thresh) ? 0 : pixel. Pass-through: data_wr = pixel.
- WRITE: wen=1, addr = pixel address, data_wr = result.
- `ready` while busy is ignored. `sel`/`thresh` changes while busy have no effect.
- Reset at any time: FSM → IDLE, all outputs → reset values, partial window discarded. Already-written pixels are not rewritten.

## Timing
- Reset values: busy=0, wen=0, iaddr=0, addr=0, data_wr=0.
- Start: `ready` high in IDLE at edge N → busy=1 and first `iaddr` driven after edge N.
- Cycles per pixel:
  - threshold/pass: 3
  - median: 20
  - mean: 11+SW (23 at DW=8)
- Frame time is cycles-per-pixel × IMG_W·IMG_H. For threshold at defaults: 49152 cycles from start to busy falling.
- busy falls the cycle after the final wen pulse. A new `ready` is accepted in that same IDLE cycle.
- wen is never high on two consecutive cycles. `addr`/`data_wr` are stable while wen=1.

## Structure
- Shared package `ife_pkg`: mode encodings (MODE_MEAN=2'b00, MODE_PASS=2'b01, MODE_MEDIAN=2'b10, MODE_THRS=2'b11) and FSM state encodings.
- One natural sub-module, `ife_window_sorter`: a 9×DW register array with start/done, 9-pass odd-even transposition, median output.
- Counters, border logic, divider and FSM stay in the top.

## Test plan
- IMG_W=IMG_H=4, threshold, thresh=127, pixels 0..15 scaled ×16 → outputs 0 for inputs <127, else unchanged; exactly 16 wen pulses; busy high for 48 cycles.
- Median on 4×4: all 50 with a single 255 impulse at (1,1) → every output 50 except the corners. Zero padding leaves 5 taps at 0 there, so corners output 0.
- Mean on 4×4 all 255 → corner 113 (1020/9), edge 170 (1530/9), interior 255.
- Pass-through on 128×128 with random data → output image identical to input; last write addr=16383.
- `ready` pulsed mid-frame with a `sel` change → ignored, mode unchanged; `reset` asserted mid-median → outputs at reset values next cycle; new start runs the full frame correctly.
- Boundary `thresh`: thresh=0 → all pixels pass; thresh=255 → only 255 passes.
